mpt_store_check: RTL
====================

# mpt_store_check

Memory-protection-table (MPT) permission checker that sits directly downstream of the store buffer's commit-queue head. It answers the store buffer's `mptw_enable` request with a `mptw_valid`/`mptw_allow` pair. The answer comes from a small fully-associative permission-bitmap cache, or from a single-level table walk to memory on a miss. The store buffer only raises `data_req` to the D$ after this block returns `allow`.

## Interface
Parameters:
- `CVA6Cfg`, `config_pkg::cva6_cfg_empty`: core configuration; uses `PLEN` and `XLEN` (`XLEN` must be 64).
- `NR_ENTRIES`, 4: number of permission-cache entries (power of two, ≥2).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous reset, active-low.
- `flush_i` in 1: invalidate all cache entries.
- `mpt_en_i` in 1: MPT checking enabled; when 0, every store is allowed.
- `mpt_base_i` in PLEN-12: PPN of the table root.
- `mptw_enable_i` in 1: store buffer requests a check for `paddr_i`.
- `paddr_i` in PLEN: physical address of the commit-queue head store.
- `mptw_valid_o` out 1: one-cycle response strobe.
- `mptw_allow_o` out 1: write permitted; meaningful only while `mptw_valid_o` is high.
- `walk_req_o` out 1: table-entry read request.
- `walk_addr_o` out PLEN: table-entry address (8-byte aligned).
- `walk_gnt_i` in 1: request accepted.
- `walk_rvalid_i` in 1: read data valid.
- `walk_rdata_i` in 64: table entry (bitmap of 64 pages).
- `walk_err_i` in 1: bus error, qualified by `walk_rvalid_i`.

## Operation
- **Table format.**
  - One 64-bit entry covers 64 consecutive 4 KiB pages.
  - Group index `gidx = paddr[PLEN-1:18]`.
  - `walk_addr_o = ({mpt_base_i,12'b0} + (gidx << 3))`, truncated to PLEN bits, with wrap.
  - Bit `paddr[17:12]` of the entry is the write permission for that page.
- **Cache entry.** Each entry holds `valid`, tag `gidx`, and the 64-bit bitmap. Replacement is round-robin: a victim pointer advances on each fill and wraps at `NR_ENTRIES-1`→0.
- **FSM states:**
  - **IDLE:** when `mptw_enable_i` is high, register `paddr_i` and go to LOOKUP.
  - **LOOKUP:**
    - If `mpt_en_i` = 0: respond allow=1, go to IDLE.
    - On a cache hit: respond with the bitmap bit, go to IDLE.
    - On a miss: go to WALK_REQ.
  - **WALK_REQ:** hold `walk_req_o`=1 with a stable `walk_addr_o` until `walk_gnt_i`, then go to WALK_WAIT.
  - **WALK_WAIT:** on `walk_rvalid_i`:
    - If `walk_err_i`: respond allow=0, no fill.
    - Otherwise: fill the victim entry and respond with the bit.
    - Go to IDLE.
- **Response.** `mptw_valid_o` is high for exactly one cycle (the responding state's cycle).
- **Enable dropped mid-check.** If `mptw_enable_i` drops before the response, the walk still completes and fills the cache; the response strobe is still driven and the store buffer ignores it.
- **Flush.**
  - All valid bits clear on the next edge.
  - A walk in flight completes and responds, but does not fill the cache.
  - A flush in the same cycle as a hit still returns the hit result.
- **Two entries with the same tag.** Cannot occur: a fill only happens after a miss on that tag, and flush suppresses fills.

## Timing
- **Reset values:** `mptw_valid_o`=0, `mptw_allow_o`=0, `walk_req_o`=0, `walk_addr_o`=0, all entries invalid, victim pointer 0, state IDLE.
- **Hit latency:** enable seen in cycle N → `mptw_valid_o` in cycle N+1.
- **Miss latency:** `walk_req_o` is high from N+2. With gnt in cycle G and rvalid in cycle R>G, the response is in cycle R (combinational from `walk_rvalid_i`).
- **Back-to-back checks:** the cycle after a response, IDLE may accept a new enable. Minimum spacing is 2 cycles per check.
- **Asynchronous reset mid-walk:** all state returns to reset values. A stale `walk_rvalid_i` arriving in IDLE is ignored.
- **Input stability:** `paddr_i` is sampled only in IDLE; later changes are ignored until the next check.

## Configuration
- `MPT_STORE_CHECK_CACHE_EN` defined: permission cache present, behaviour as above.
- `MPT_STORE_CHECK_CACHE_EN` undefined:
  - The cache and victim pointer are removed, and `flush_i` is ignored.
  - LOOKUP always misses when `mpt_en_i` = 1.
  - Every check walks; latencies are unchanged otherwise.

## Structure
- **In `ariane_pkg`:**
  - `MPT_PAGES_PER_ENTRY` = 64 and `MPT_ENTRY_BYTES` = 8.
  - `mpt_state_e` {IDLE, LOOKUP, WALK_REQ, WALK_WAIT}.
  - Parametric struct `mpt_cache_entry_t` {valid, tag, bitmap}.
- **Sub-module `mpt_perm_cache`:**
  - Holds the entry storage, the tag compare (hit and bitmap out), the fill port, flush, and the round-robin victim pointer.
  - Instantiated only under `MPT_STORE_CHECK_CACHE_EN`.

## Test plan
- **Disabled:** `mpt_en_i`=0, enable with `paddr=0x8000_1000` → valid+allow=1 in cycle N+1, `walk_req_o` never high.
- **Cold miss:** base PPN 0x80100, `paddr=0x8004_3000` → `walk_addr_o=0x8010_0000+(0x2001<<3)=0x8011_0008`; rdata with bit 3 set → allow=1. A repeat check hits with 1-cycle latency and no walk.
- **Denied page and hit:** same group with bit 4 clear, `paddr=0x8004_4000` → hit, allow=0.
- **Walk error:** gnt after 3 cycles, rvalid+err → allow=0. A repeat check walks again (no fill).
- **Flush mid-walk:** `flush_i` during WALK_WAIT → the response is still delivered; the next check of the same address walks.
- **Round-robin eviction:** `NR_ENTRIES`+1 distinct groups → the first group misses again; the victim pointer wraps to 1.

Source files
------------

// File: rtl/mpt_store_check_pkg.sv
// Shared definitions for the MPT store permission checker.
//
// Contents:
//   cva6_cfg_t / cva6_cfg_empty : the slice of the core configuration this
//                                 block uses (PLEN, XLEN).
//   MPT_* localparams           : table geometry (64 pages per 8-byte entry).
//   mpt_state_e                 : checker FSM states.
//   mpt_cache_entry_t           : one permission-cache line {valid, tag, bitmap}.
//                                 The tag field is sized for the widest legal
//                                 PLEN (64); narrower group indices are
//                                 zero-extended into it.
//   mpt_page_allowed()          : selects the write-permission bit of a page.
package mpt_store_check_pkg;

  typedef struct packed {
    int unsigned PLEN;
    int unsigned XLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{PLEN: 56, XLEN: 64};

  localparam int unsigned MPT_PAGES_PER_ENTRY = 64;
  localparam int unsigned MPT_ENTRY_BYTES     = 8;
  // One entry covers 64 pages of 4 KiB, so the group index starts at bit 18.
  localparam int unsigned MPT_GROUP_SHIFT     = 18;
  localparam int unsigned MPT_TAG_W           = 64 - MPT_GROUP_SHIFT;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WALK_REQ,
    WALK_WAIT
  } mpt_state_e;

  typedef struct packed {
    logic                           valid;
    logic [MPT_TAG_W-1:0]           tag;
    logic [MPT_PAGES_PER_ENTRY-1:0] bitmap;
  } mpt_cache_entry_t;

  function automatic logic mpt_page_allowed(input logic [MPT_PAGES_PER_ENTRY-1:0] bitmap,
                                            input logic [5:0]                     page_idx);
    return bitmap[page_idx];
  endfunction

endpackage

// File: rtl/mpt_store_check_perm_cache.sv
// mpt_perm_cache: fully-associative cache of MPT permission bitmaps.
//
// Ports:
//   clk_i, rst_ni    : clock, asynchronous active-low reset.
//   flush_i          : clear every valid bit on the next edge (wins over fill).
//   lookup_tag_i     : group index to look up.
//   hit_o            : a valid entry with lookup_tag_i exists (combinational).
//   hit_bitmap_o     : bitmap of the hitting entry, zero on a miss.
//   fill_i           : write {fill_tag_i, fill_bitmap_i} into the victim entry.
//   fill_tag_i       : group index of the fill.
//   fill_bitmap_i    : 64-bit permission bitmap of the fill.
//
// Replacement is round-robin: the victim pointer advances on every fill and
// wraps naturally because NR_ENTRIES is a power of two.
module mpt_perm_cache
  import mpt_store_check_pkg::*;
#(
  parameter  int unsigned NR_ENTRIES = 4,
  localparam int unsigned IDX_W      = $clog2(NR_ENTRIES)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic [MPT_TAG_W-1:0]           lookup_tag_i,
  output logic                           hit_o,
  output logic [MPT_PAGES_PER_ENTRY-1:0] hit_bitmap_o,
  input  logic                           fill_i,
  input  logic [MPT_TAG_W-1:0]           fill_tag_i,
  input  logic [MPT_PAGES_PER_ENTRY-1:0] fill_bitmap_i
);

  mpt_cache_entry_t entries_q [NR_ENTRIES];
  logic [IDX_W-1:0] victim_q;

  // Fills only follow a miss on the same tag, so at most one entry matches.
  always_comb begin
    hit_o        = 1'b0;
    hit_bitmap_o = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (entries_q[i].valid && (entries_q[i].tag == lookup_tag_i)) begin
        hit_o        = 1'b1;
        hit_bitmap_o = entries_q[i].bitmap;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
      victim_q <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else if (fill_i) begin
      entries_q[victim_q] <= '{valid: 1'b1, tag: fill_tag_i, bitmap: fill_bitmap_i};
      victim_q            <= victim_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/mpt_store_check.sv
// mpt_store_check: MPT write-permission checker for the store buffer head.
//
// A check is requested with mptw_enable_i; the answer is a one-cycle
// mptw_valid_o strobe with mptw_allow_o. Hits in the permission cache answer
// one cycle after the request; misses read one 64-bit table entry
// ({mpt_base_i,12'b0} + gidx*8) and answer in the walk_rvalid_i cycle.
//
// Handshakes: walk_req_o is held high with a stable walk_addr_o until the
// cycle walk_gnt_i is seen high (request transferred on that edge); the data
// phase completes in the first later cycle with walk_rvalid_i high, with
// walk_err_i qualified by walk_rvalid_i. mptw_valid_o is a pure strobe with no
// back-pressure; it fires even if mptw_enable_i has dropped meanwhile.
//
// Ports: clk_i, rst_ni (async, active-low), flush_i, mpt_en_i, mpt_base_i,
//   mptw_enable_i, paddr_i, mptw_valid_o, mptw_allow_o, walk_req_o,
//   walk_addr_o, walk_gnt_i, walk_rvalid_i, walk_rdata_i, walk_err_i,
//   dbg_state_o (current FSM state, for observation only).
//
// Build option: define MPT_STORE_CHECK_CACHE_EN to include the permission
// cache. Without it every enabled check walks and flush_i has no effect.
module mpt_store_check
  import mpt_store_check_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg    = cva6_cfg_empty,
  parameter int unsigned NR_ENTRIES = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     mpt_en_i,
  input  logic [CVA6Cfg.PLEN-13:0] mpt_base_i,
  input  logic                     mptw_enable_i,
  input  logic [CVA6Cfg.PLEN-1:0]  paddr_i,
  output logic                     mptw_valid_o,
  output logic                     mptw_allow_o,
  output logic                     walk_req_o,
  output logic [CVA6Cfg.PLEN-1:0]  walk_addr_o,
  input  logic                     walk_gnt_i,
  input  logic                     walk_rvalid_i,
  input  logic [63:0]              walk_rdata_i,
  input  logic                     walk_err_i,
  output mpt_state_e               dbg_state_o
);

  localparam int unsigned PLEN   = CVA6Cfg.PLEN;
  localparam int unsigned GIDX_W = PLEN - MPT_GROUP_SHIFT;

  mpt_state_e        state_q, state_d;
  logic [PLEN-13:0]  ppn_q;
  logic [PLEN-1:0]   walk_addr_q, walk_addr_d;
  logic              flush_pend_q, flush_pend_d;
  logic              capture;
  logic              fill;
  logic [GIDX_W-1:0] gidx;
  logic [5:0]        page_idx;
  logic [PLEN-1:0]   walk_addr_calc;
  logic              cache_hit;
  logic [63:0]       cache_bitmap;

  logic unused_paddr_lo;
  assign unused_paddr_lo = ^paddr_i[11:0];

  assign gidx     = ppn_q[PLEN-13:6];
  assign page_idx = ppn_q[5:0];

  // Entries are 8 bytes, hence gidx shifted left by 3; the sum wraps at PLEN.
  assign walk_addr_calc = {mpt_base_i, 12'h000} + {{(PLEN-GIDX_W-3){1'b0}}, gidx, 3'b000};

`ifdef MPT_STORE_CHECK_CACHE_EN
  mpt_perm_cache #(
    .NR_ENTRIES(NR_ENTRIES)
  ) i_perm_cache (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .lookup_tag_i (MPT_TAG_W'(gidx)),
    .hit_o        (cache_hit),
    .hit_bitmap_o (cache_bitmap),
    .fill_i       (fill),
    .fill_tag_i   (MPT_TAG_W'(gidx)),
    .fill_bitmap_i(walk_rdata_i)
  );
`else
  assign cache_hit    = 1'b0;
  assign cache_bitmap = '0;
  logic unused_cache;
  assign unused_cache = fill ^ (|cache_bitmap);
`endif

  always_comb begin
    state_d      = state_q;
    walk_addr_d  = walk_addr_q;
    // Any flush seen while a check is in progress blocks that check's fill,
    // so a bitmap read before the flush cannot land in the cache after it.
    flush_pend_d = flush_pend_q | flush_i;
    capture      = 1'b0;
    fill         = 1'b0;
    mptw_valid_o = 1'b0;
    mptw_allow_o = 1'b0;
    case (state_q)
      IDLE: begin
        flush_pend_d = 1'b0;
        if (mptw_enable_i) begin
          capture = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!mpt_en_i) begin
          mptw_valid_o = 1'b1;
          mptw_allow_o = 1'b1;
          state_d      = IDLE;
        end else if (cache_hit) begin
          mptw_valid_o = 1'b1;
          mptw_allow_o = mpt_page_allowed(cache_bitmap, page_idx);
          state_d      = IDLE;
        end else begin
          walk_addr_d = walk_addr_calc;
          state_d     = WALK_REQ;
        end
      end
      WALK_REQ: begin
        if (walk_gnt_i) begin
          state_d = WALK_WAIT;
        end
      end
      WALK_WAIT: begin
        if (walk_rvalid_i) begin
          mptw_valid_o = 1'b1;
          if (!walk_err_i) begin
            mptw_allow_o = mpt_page_allowed(walk_rdata_i, page_idx);
            fill         = !(flush_pend_q || flush_i);
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ppn_q        <= '0;
      walk_addr_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      walk_addr_q  <= walk_addr_d;
      flush_pend_q <= flush_pend_d;
      if (capture) begin
        ppn_q <= paddr_i[PLEN-1:12];
      end
    end
  end

  assign walk_req_o  = (state_q == WALK_REQ);
  assign walk_addr_o = walk_addr_q;
  assign dbg_state_o = state_q;

endmodule
